// File: rtl/ring_phase_decoder.sv
// Checks the ring counter's one-hot phase bus for legal rotate-left advances
// and decodes it to a zone index with step/lap strobes, sticky errors and resync.
module ring_phase_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] phase_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             step_pulse,
    output logic             lap_pulse,
    output logic [CNT_W-1:0] lap_count,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             resync_req
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ph_r;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] succ;
    logic [WIDTH-1:0] bit0;
    logic             legal;

    function automatic logic [IDX_W-1:0] enc(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign legal = (ph_r != '0) && ((ph_r & (ph_r - WIDTH'(1))) == '0);
    assign succ  = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign bit0  = WIDTH'(1);

    assign idx_valid  = (state == LOCKED);
    assign resync_req = (state == FAULT);

    // Sticky flags: clr_err is applied first so a same-cycle detection wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SYNC;
            ph_r       <= '0;
            prev       <= '0;
            idx_out    <= '0;
            step_pulse <= 1'b0;
            lap_pulse  <= 1'b0;
            lap_count  <= '0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            ph_r       <= phase_in;
            step_pulse <= 1'b0;
            lap_pulse  <= 1'b0;
            if (clr_err) begin
                err_onehot <= 1'b0;
                err_seq    <= 1'b0;
            end
            case (state)
                SYNC: begin
                    if (legal) begin
                        state   <= LOCKED;
                        prev    <= ph_r;
                        idx_out <= enc(ph_r);
                    end
                end
                LOCKED: begin
                    if (ph_r == prev) begin
                        state <= LOCKED;
                    end else if (ph_r == succ) begin
                        prev       <= ph_r;
                        idx_out    <= enc(ph_r);
                        step_pulse <= 1'b1;
                        if (prev[WIDTH-1]) begin
                            lap_pulse <= 1'b1;
                            lap_count <= lap_count + CNT_W'(1);
                        end
                    end else if (!legal) begin
                        err_onehot <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        err_seq <= 1'b1;
                        state   <= FAULT;
                    end
                end
                FAULT: begin
                    if (ph_r == bit0) begin
                        state   <= LOCKED;
                        prev    <= bit0;
                        idx_out <= '0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Bench for ring_phase_decoder: fixed vector table, randomized run against an
// index-arithmetic reference model, and hand sequences for laps and reset.
module tb_ring_phase_decoder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] phase_in;
    logic             clr_err;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             step_pulse;
    logic             lap_pulse;
    logic [CNT_W-1:0] lap_count;
    logic             err_onehot;
    logic             err_seq;
    logic             resync_req;

    ring_phase_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .phase_in   (phase_in),
        .clr_err    (clr_err),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .step_pulse (step_pulse),
        .lap_pulse  (lap_pulse),
        .lap_count  (lap_count),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .resync_req (resync_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: mode 0 = waiting, 1 = locked, 2 = faulted
    logic [WIDTH-1:0] m_ph_r;
    int m_mode, m_pidx, m_idx, m_step, m_lap, m_lapcnt, m_eoh, m_eseq;

    typedef struct {
        logic [WIDTH-1:0] ph;
        int clr, idx, valid, step, lap, lcnt, eoh, eseq, rs;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hot_pos(input logic [WIDTH-1:0] v);
        int p;
        p = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic model_reset();
        m_ph_r = '0; m_mode = 0; m_pidx = 0; m_idx = 0; m_step = 0; m_lap = 0;
        m_lapcnt = 0; m_eoh = 0; m_eseq = 0;
    endtask

    task automatic model_edge(input logic [WIDTH-1:0] ph, input logic clr);
        int ones, p;
        ones = $countones(m_ph_r);
        p = hot_pos(m_ph_r);
        m_step = 0;
        m_lap = 0;
        if (clr) begin
            m_eoh = 0;
            m_eseq = 0;
        end
        if (m_mode == 0) begin
            if (ones == 1) begin
                m_mode = 1; m_pidx = p; m_idx = p;
            end
        end else if (m_mode == 1) begin
            if (ones != 1) begin
                m_eoh = 1; m_mode = 2;
            end else if (p == m_pidx) begin
                m_mode = 1;
            end else if (p == (m_pidx + 1) % WIDTH) begin
                m_step = 1;
                if (m_pidx == WIDTH - 1) begin
                    m_lap = 1;
                    m_lapcnt = (m_lapcnt + 1) % (1 << CNT_W);
                end
                m_pidx = p; m_idx = p;
            end else begin
                m_eseq = 1; m_mode = 2;
            end
        end else begin
            if (ones == 1 && p == 0) begin
                m_mode = 1; m_pidx = 0; m_idx = 0;
            end
        end
        m_ph_r = ph;
    endtask

    task automatic check_model();
        check("idx_out", int'(idx_out), m_idx);
        check("idx_valid", int'(idx_valid), int'(m_mode == 1));
        check("step_pulse", int'(step_pulse), m_step);
        check("lap_pulse", int'(lap_pulse), m_lap);
        check("lap_count", int'(lap_count), m_lapcnt);
        check("err_onehot", int'(err_onehot), m_eoh);
        check("err_seq", int'(err_seq), m_eseq);
        check("resync_req", int'(resync_req), int'(m_mode == 2));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx"}, int'(idx_out), 0);
        check({tag, "_valid"}, int'(idx_valid), 0);
        check({tag, "_step"}, int'(step_pulse), 0);
        check({tag, "_lap"}, int'(lap_pulse), 0);
        check({tag, "_lcnt"}, int'(lap_count), 0);
        check({tag, "_eoh"}, int'(err_onehot), 0);
        check({tag, "_eseq"}, int'(err_seq), 0);
        check({tag, "_resync"}, int'(resync_req), 0);
    endtask

    // One clock: drive inputs, take the edge, step the model, compare #1 later.
    task automatic tick(input logic [WIDTH-1:0] ph, input logic clr);
        phase_in = ph;
        clr_err = clr;
        @(posedge clk);
        model_edge(ph, clr);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        phase_in = '0;
        clr_err = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lap_and_check(input int exp);
        for (int k = 1; k <= WIDTH; k++) tick(WIDTH'(1 << (k % WIDTH)), 1'b0);
        tick(WIDTH'(1), 1'b0);
        check("lap_count_after_lap", int'(lap_count), exp);
    endtask

    initial begin
        logic [WIDTH-1:0] ph;
        int cur_i, r;

        rst = 1'b1;
        phase_in = '0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // ph, clr, idx, valid, step, lap, lcnt, eoh, eseq, resync (after the edge)
        tbl.push_back('{4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 1, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 1, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0100, 0, 1, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0100, 0, 2, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0100, 0, 2, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b1000, 0, 2, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b1000, 0, 3, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b1000, 0, 3, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 3, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 0, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 1, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0110, 0, 1, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0110, 0, 1, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{4'b0001, 0, 1, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{4'b0001, 1, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b0010, 0, 1, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b1000, 0, 1, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{4'b1000, 0, 1, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{4'b0100, 0, 1, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{4'b0100, 0, 1, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{4'b0001, 0, 1, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{4'b0010, 0, 0, 1, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{4'b0110, 0, 1, 1, 1, 0, 1, 0, 1, 0});
        tbl.push_back('{4'b0110, 1, 1, 0, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{4'b0000, 1, 1, 0, 0, 0, 1, 0, 0, 1});
        tbl.push_back('{4'b0001, 0, 1, 0, 0, 0, 1, 0, 0, 1});
        tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            tick(tbl[i].ph, tbl[i].clr[0]);
            check("tbl_idx", int'(idx_out), tbl[i].idx);
            check("tbl_valid", int'(idx_valid), tbl[i].valid);
            check("tbl_step", int'(step_pulse), tbl[i].step);
            check("tbl_lap", int'(lap_pulse), tbl[i].lap);
            check("tbl_lcnt", int'(lap_count), tbl[i].lcnt);
            check("tbl_eoh", int'(err_onehot), tbl[i].eoh);
            check("tbl_eseq", int'(err_seq), tbl[i].eseq);
            check("tbl_resync", int'(resync_req), tbl[i].rs);
        end

        cur_i = 0;
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                cur_i = (cur_i + 1) % WIDTH;
                ph = WIDTH'(1 << cur_i);
            end else if (r < 72) begin
                ph = WIDTH'(1 << cur_i);
            end else if (r < 80) begin
                cur_i = $urandom_range(0, WIDTH - 1);
                ph = WIDTH'(1 << cur_i);
            end else if (r < 88) begin
                ph = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            end else begin
                cur_i = 0;
                ph = WIDTH'(1);
            end
            tick(ph, ($urandom_range(0, 19) == 0));
        end

        do_reset();
        tick(WIDTH'(1), 1'b0);
        tick(WIDTH'(1), 1'b0);
        check("lock_valid", int'(idx_valid), 1);
        lap_and_check(1);
        lap_and_check(2);
        lap_and_check(3);
        lap_and_check(0);
        lap_and_check(1);
        lap_and_check(2);
        lap_and_check(3);

        // Leave a sticky error set, recover, then park at index 2.
        tick(4'b1000, 1'b0);
        tick(4'b0100, 1'b0);
        check("skip_eseq", int'(err_seq), 1);
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        check("pre_rst_idx", int'(idx_out), 2);
        check("pre_rst_lcnt", int'(lap_count), 3);
        check("pre_rst_eseq", int'(err_seq), 1);
        check("pre_rst_valid", int'(idx_valid), 1);

        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(4'b0100, 1'b0);
        check("post_rst_valid0", int'(idx_valid), 0);
        tick(4'b0100, 1'b0);
        check("post_rst_valid", int'(idx_valid), 1);
        check("post_rst_idx", int'(idx_out), 2);
        check("post_rst_err", int'(err_onehot | err_seq), 0);
        tick(4'b0100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ring_phase_decoder.md
# ring_phase_decoder

Consumer of the one-hot phase vector produced by the irrigation ring counter. Samples the phase bus each clock, checks that it is one-hot and advances by exactly one rotate-left step, and converts it to a binary zone index with step and lap strobes. On any illegal pattern it latches sticky error flags and requests a counter resync. It sits between the ring counter and the valve/zone control logic.

## Interface
- WIDTH, 4, number of ring phases (≥2)
- CNT_W, 8, width of the lap counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- phase_in  in  WIDTH  one-hot phase from the ring counter, same clock domain
- clr_err  in  1  synchronous clear of sticky error flags
- idx_out  out  $clog2(WIDTH)  binary index of the current hot bit
- idx_valid  out  1  high while state is LOCKED
- step_pulse  out  1  one-cycle strobe per legal phase advance
- lap_pulse  out  1  one-cycle strobe on wrap from bit WIDTH-1 to bit 0
- lap_count  out  CNT_W  number of completed laps, modulo 2^CNT_W
- err_onehot  out  1  sticky: non-one-hot pattern seen while LOCKED
- err_seq  out  1  sticky: legal one-hot but not the expected successor
- resync_req  out  1  high while in FAULT; drives the ring counter's reset

## Operation
- Input stage: ph_r <= phase_in every edge; reset value all-zero. All checks use ph_r against prev (last accepted phase, reset value all-zero).
- Legal = exactly one bit set. Successor = rotate-left of prev (bit WIDTH-1 -> bit 0).
- States: SYNC (reset state), LOCKED, FAULT.
- SYNC: non-legal ph_r ignored, no error. Legal ph_r -> LOCKED, prev <= ph_r, idx_out <= its position; no step_pulse.
- LOCKED, ph_r == prev: hold, no strobes.
- LOCKED, ph_r == successor: prev <= ph_r, idx_out updated, step_pulse = 1; if prev bit WIDTH-1 was set, also lap_pulse = 1 and lap_count += 1 (wraps to 0 after 2^CNT_W-1).
- LOCKED, ph_r not legal (incl. all-zero, multi-hot): err_onehot <= 1, -> FAULT.
- LOCKED, ph_r legal but neither prev nor successor (skip or reverse): err_seq <= 1, -> FAULT.
- FAULT: resync_req = 1, idx_valid = 0, idx_out holds last value, no strobes, no new error setting. When ph_r == bit 0 only -> LOCKED, prev <= bit 0, idx_out <= 0, no strobes.
- clr_err: clears both sticky flags next edge; if a new error is detected in the same cycle, set wins. clr_err does not change state.
- lap_count cleared only by rst.
- rst mid-operation: all registers to reset values immediately (async); restart in SYNC.

## Timing
- Reset values: idx_out 0, idx_valid 0, step_pulse 0, lap_pulse 0, lap_count 0, err_onehot 0, err_seq 0, resync_req 0, state SYNC.
- All outputs registered. phase_in change visible on ph_r after edge k; decision outputs (step_pulse, lap_pulse, idx_out, lap_count, error flags, state) update at edge k+1: 2-cycle latency from phase_in to strobe.
- idx_valid, resync_req are decoded from registered state; they change on the same edge as the state transition.
- step_pulse/lap_pulse high for exactly one cycle per advance; a phase advancing every clock yields step_pulse high continuously.
- Back-to-back: an error detected on edge k+1 moves to FAULT; resync_req high from that edge until the edge that accepts ph_r == bit 0.

## Test plan
- Reset then phase_in = 0001 held -> after 2 edges idx_valid = 1, idx_out = 0, no step_pulse, no errors.
- Drive 0001,0010,0100,1000,0001 one per 3 clocks -> four step_pulses, idx_out 1,2,3,0, one lap_pulse on the 1000->0001 step, lap_count = 1.
- Locked at 0010, drive 0110 -> err_onehot = 1, resync_req = 1, idx_valid = 0; then 0001 -> LOCKED, idx_out = 0, err_onehot still 1 until clr_err pulse, then 0.
- Locked at 0010, drive 1000 (skip) -> err_seq = 1, err_onehot = 0, FAULT; drive 0100 -> stays FAULT; drive 0001 -> LOCKED.
- CNT_W = 2, run 4 full laps -> lap_count 1,2,3,0; clr_err asserted in same cycle as new error -> flag stays 1.
- Assert rst while LOCKED at idx 2 with lap_count 3 and errors set -> all outputs to reset values immediately; release with phase_in 0100 -> LOCKED at idx_out 2, no error.
